a2d_seq: RTL
============

# a2d_seq

Round-robin conversion sequencer for the external A2D converter behind the SPI monarch. Each request converts one channel: left load cell, right load cell, steering pot or battery. The 12-bit result is held in a per-channel register. The lft_ld and rght_ld outputs feed rider detection and steer enable directly, and ld_vld marks a fresh left/right load pair. A timeout watchdog recovers from a hung SPI transaction.

## Interface
- CH_LFT, 3'd0, A2D channel for left load cell
- CH_RGHT, 3'd4, A2D channel for right load cell
- CH_STEER, 3'd5, A2D channel for steering pot
- CH_BATT, 3'd6, A2D channel for battery
- TMO_CYC, 16'd4096, cycles allowed per SPI transaction before abort
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  asynchronous active-low reset
- nxt  input  1  request one conversion of the current round-robin channel
- done  input  1  SPI monarch transaction complete, one-cycle pulse
- rd_data  input  16  SPI monarch receive word; valid in the cycle done is high
- wrt  output  1  start SPI transaction, one-cycle pulse
- cmd  output  16  SPI command word
- lft_ld, rght_ld, steer_pot, batt  output  12 each  latest conversion per channel
- ld_vld  output  1  one-cycle pulse when rght_ld updates, which completes a left/right pair
- busy  output  1  sequence in progress
- tmo_err  output  1  sticky timeout flag, cleared only by reset

## Operation
- Round-robin pointer rr[1:0] selects the channel: 0 = lft, 1 = rght, 2 = steer, 3 = batt. Reset value is 0.
- States:
  - IDLE: busy=0. If nxt is sampled high, load cmd = {2'b00, ch[rr], 11'h000}, pulse wrt and go to CNV.
  - CNV: wait for the first done, then go to GAP.
  - GAP: spend exactly one cycle here. Pulse wrt with cmd unchanged and go to RD.
  - RD: wait for done. Capture rd_data[11:0] into the register selected by rr. Advance rr by 1, wrapping 3 to 0. Pulse ld_vld if rr was 1. Return to IDLE.
- nxt while not in IDLE is ignored. It is not queued.
- The upper bits rd_data[15:12] are discarded. Only the register selected by rr is written; the other three hold.
- Watchdog: a counter clears on every wrt and increments each cycle in CNV or RD.
  - When it reaches TMO_CYC-1 without done, abort to IDLE, set tmo_err and leave rr unchanged, so the next nxt retries the same channel.
  - No data register is written on abort.
  - If done arrives in the same cycle as the timeout, done wins and the transaction completes normally.
- A done pulse seen in IDLE or GAP is ignored.
- Asserting rst_n low at any point, including mid-sequence, returns the FSM to IDLE immediately.

## Timing
- All outputs are registered.
- Reset values: wrt=0, cmd=16'h0000, busy=0, ld_vld=0, tmo_err=0, rr=0, all four data registers 12'h000.
- wrt goes high the cycle after the edge that samples nxt in IDLE, and stays high for exactly one cycle.
- busy is high from the same cycle as the first wrt through the cycle the FSM re-enters IDLE.
- The second wrt is high exactly 2 cycles after the cycle in which the first done is high.
- The data register and ld_vld update on the edge that samples the second done. Both are visible the following cycle; ld_vld lasts one cycle.
- cmd stays stable from the first wrt until the FSM returns to IDLE.
- Minimum issue rate: nxt held high continuously starts a new sequence in the cycle after busy drops.

## Test plan
- Reset, then nxt pulse; responder returns rd_data 16'hF123 on the second done.
  - cmd = 16'h0000 with two wrt pulses.
  - lft_ld = 12'h123, rr = 1, no ld_vld.
- Four consecutive sequences with data 0x111, 0x222, 0x333, 0x444.
  - cmd sequence is 16'h0000, 16'h2000, 16'h2800, 16'h3000.
  - Registers end at lft 0x111, rght 0x222, steer 0x333, batt 0x444.
  - ld_vld pulses once, after the second sequence.
  - A fifth nxt wraps back to lft.
- Responder never asserts done after the first wrt.
  - After TMO_CYC cycles: tmo_err=1, busy=0, registers unchanged.
  - Next nxt reissues cmd 16'h0000.
- nxt pulsed in CNV, GAP and RD: no extra wrt, and exactly one register update results.
- Spurious done in IDLE: no state change and no wrt.
- rst_n asserted during RD, then released: all outputs at reset values, and the next nxt starts at lft.

Source files
------------

// File: rtl/a2d_seq.sv
// a2d_seq: round-robin conversion sequencer for the external A2D converter.
// Each nxt request runs two SPI transactions on the current channel (start
// conversion, then read back), stores the 12-bit result in that channel's
// register and advances to the next channel. A watchdog aborts a transaction
// that never completes and raises a sticky error flag.
module a2d_seq #(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter logic [15:0] TMO_CYC  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        ld_vld,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNV  = 2'd1,
    GAP  = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [15:0] cmd_q, cmd_d;
  logic        wrt_q, wrt_d;
  logic        busy_q, busy_d;
  logic        ld_vld_q, ld_vld_d;
  logic        tmo_err_q, tmo_err_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;

  logic        tmo_hit_s;
  logic [11:0] rd_lo_s;
  logic [3:0]  unused_rd_hi_s;

  // Command word for the channel selected by the round-robin pointer.
  function automatic logic [15:0] chan_cmd(input logic [1:0] sel);
    logic [2:0] ch;
    case (sel)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      2'd2:    ch = CH_STEER;
      2'd3:    ch = CH_BATT;
      default: ch = CH_LFT;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  // The converter result is the low 12 bits; the upper nibble is dropped.
  assign rd_lo_s        = rd_data[11:0];
  assign unused_rd_hi_s = rd_data[15:12];
  assign tmo_hit_s      = (tmo_cnt_q == (TMO_CYC - 16'd1));

  // Next-state, datapath and watchdog logic for the conversion sequence.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cmd_d     = cmd_q;
    wrt_d     = 1'b0;
    ld_vld_d  = 1'b0;
    tmo_err_d = tmo_err_q;
    lft_d     = lft_q;
    rght_d    = rght_q;
    steer_d   = steer_q;
    batt_d    = batt_q;

    case (state_q)
      IDLE: begin
        if (nxt) begin
          cmd_d   = chan_cmd(rr_q);
          wrt_d   = 1'b1;
          state_d = CNV;
        end else begin
          state_d = IDLE;
        end
      end
      CNV: begin
        // done takes priority over a coincident timeout
        if (done) begin
          state_d = GAP;
        end else if (tmo_hit_s) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          state_d = CNV;
        end
      end
      GAP: begin
        wrt_d   = 1'b1;
        state_d = RD;
      end
      RD: begin
        if (done) begin
          case (rr_q)
            2'd0:    lft_d   = rd_lo_s;
            2'd1:    rght_d  = rd_lo_s;
            2'd2:    steer_d = rd_lo_s;
            2'd3:    batt_d  = rd_lo_s;
            default: batt_d  = batt_q;
          endcase
          rr_d     = rr_q + 2'd1;
          ld_vld_d = (rr_q == 2'd1);
          state_d  = IDLE;
        end else if (tmo_hit_s) begin
          // abort keeps rr so the next request retries the same channel
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wrt_d) begin
      tmo_cnt_d = 16'h0000;
    end else if ((state_q == CNV) || (state_q == RD)) begin
      tmo_cnt_d = tmo_cnt_q + 16'h0001;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 2'd0;
      cmd_q     <= 16'h0000;
      wrt_q     <= 1'b0;
      busy_q    <= 1'b0;
      ld_vld_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_cnt_q <= 16'h0000;
      lft_q     <= 12'h000;
      rght_q    <= 12'h000;
      steer_q   <= 12'h000;
      batt_q    <= 12'h000;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cmd_q     <= cmd_d;
      wrt_q     <= wrt_d;
      busy_q    <= busy_d;
      ld_vld_q  <= ld_vld_d;
      tmo_err_q <= tmo_err_d;
      tmo_cnt_q <= tmo_cnt_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      steer_q   <= steer_d;
      batt_q    <= batt_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign busy      = busy_q;
  assign ld_vld    = ld_vld_q;
  assign tmo_err   = tmo_err_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

endmodule
